slave_request_recorder: RTL
===========================

// Module: slave_request_recorder
// PURPOSE
//  Tag-indexed table of outstanding non-posted AXI-slave requests. Downstream of the
//  write/read-interface mux: takes its single req_wr_* port and records one entry per
//  issued request. Advertises the lowest free tag for the next request. The completion
//  side reads an entry by tag, then retires it, which frees the tag.
// PARAMETERS
//  DEPTH       32  number of table entries; power of two, >= 2
//  TAG_W       $clog2(DEPTH)  tag / address width (derived, not overridable)
//  REQ_DATA_W  64  recorded payload width (AXI ID, length, type, address LSBs)
// PORTS
//  clk             in   1           clock
//  arst            in   1           asynchronous reset, active-low
//  req_wr_en       in   1           record request (from interface mux)
//  req_wr_addr     in   TAG_W       tag to record into
//  req_wr_data     in   REQ_DATA_W  request payload
//  alloc_tag       out  TAG_W       lowest-numbered free tag
//  alloc_valid     out  1           at least one free tag exists
//  cpl_rd_en       in   1           look up entry by tag
//  cpl_rd_addr     in   TAG_W       lookup tag
//  cpl_rd_data     out  REQ_DATA_W  entry payload, 1 cycle after cpl_rd_en
//  cpl_rd_hit      out  1           looked-up entry was valid (aligned with cpl_rd_data)
//  cpl_free_en     in   1           retire entry
//  cpl_free_tag    in   TAG_W       tag to retire
//  occupancy       out  TAG_W+1     number of valid entries
//  full            out  1           occupancy == DEPTH
//  empty           out  1           occupancy == 0
//  err_dup_wr      out  1           1-cycle pulse: write to already-valid tag
//  err_bad_free    out  1           1-cycle pulse: free of an invalid tag
// BEHAVIOUR
//  - Reset (arst low, async): all valid bits 0; occupancy 0; empty 1; full 0;
//    alloc_valid 1; alloc_tag 0; cpl_rd_data 0; cpl_rd_hit 0; error pulses 0.
//  - State: valid[DEPTH] flops; payload RAM DEPTH x REQ_DATA_W (no reset on RAM contents).
//  - Write: req_wr_en with valid[tag]==0 -> next edge stores data, sets valid, occupancy+1.
//    With valid[tag]==1 -> entry unchanged; err_dup_wr pulses the following cycle.
//  - alloc_tag/alloc_valid: combinational from valid[] (lowest index with valid==0),
//    updating in the cycle after each write or free. With full: alloc_valid 0 and
//    alloc_tag 0. The upstream arbiter must not grant while alloc_valid is 0.
//  - Lookup: cpl_rd_en -> next cycle cpl_rd_data = RAM[tag] and cpl_rd_hit = valid[tag],
//    both sampled at the cpl_rd_en edge. Holds the value when cpl_rd_en is 0.
//  - Free: cpl_free_en with valid[tag]==1 -> valid cleared, occupancy-1.
//    With valid[tag]==0 -> no change; err_bad_free pulses the following cycle.
//  - Simultaneous write and free, different tags: both take effect; occupancy unchanged.
//  - Simultaneous write and free, same tag:
//      - entry valid: free retires it and the write is a duplicate (dropped, err_dup_wr);
//        the entry ends up invalid.
//      - entry invalid: the write records it and the free is a bad free (err_bad_free);
//        the entry ends up valid.
//  - Lookup and free of the same tag in one cycle: lookup returns pre-free data, hit=1.
//  - Lookup and write of the same tag in one cycle: lookup returns the old contents and
//    the old valid bit (no write-through).
//  - occupancy never wraps: it is derived from accepted ops only, so 0..DEPTH always holds.
//  - Reset mid-operation: in-flight lookup result is discarded; all tags are freed.
// STRUCTURE
//  - Shared package slave_bridge_pkg: entry struct (axi_id, len, req_type, addr_lsb),
//    REQ_DATA_W = $bits(struct), DEPTH constant, TAG_W.
//  - Sub-module free_tag_encoder: DEPTH-bit vector -> lowest-zero index plus any-zero
//    flag; purely combinational.
// TESTING
//  1 Reset, then write tags 0,1,2 with data A,B,C -> occupancy 3, alloc_tag 3,
//    lookup tag 1 returns B with hit=1 after 1 cycle.
//  2 Fill all 32 tags -> full 1, alloc_valid 0. Free tag 7 -> next cycle full 0,
//    alloc_tag 7, occupancy 31.
//  3 Write tag 4 twice -> err_dup_wr 1-cycle pulse, lookup returns first data.
//    Free tag 9 while empty -> err_bad_free pulse, occupancy stays 0.
//  4 Same cycle: write tag 5 and free tag 2 (both legal) -> occupancy unchanged,
//    valid[5]=1, valid[2]=0.
//  5 Same cycle: lookup tag 3 and free tag 3 -> hit 1 with old data; next lookup
//    of tag 3 -> hit 0.
//  6 Fill 10 entries, assert arst mid-lookup -> all outputs at reset values
//    immediately, occupancy 0, alloc_tag 0.

Source files
------------

// File: rtl/slave_bridge_pkg.sv
// Shared definitions for the AXI-slave bridge request path.
// Provides the recorded request entry layout, the table depth and the
// derived tag width used by the outstanding-request recorder.
package slave_bridge_pkg;

    localparam int DEPTH = 32;
    localparam int TAG_W = $clog2(DEPTH);

    typedef enum logic [7:0] {
        REQ_READ     = 8'h00,
        REQ_WRITE_NP = 8'h01,
        REQ_ATOMIC   = 8'h02
    } req_type_e;

    // Payload stored per outstanding request; completion logic needs these
    // fields to rebuild the AXI response.
    typedef struct packed {
        logic [15:0] axi_id;
        logic [7:0]  len;
        req_type_e   req_type;
        logic [31:0] addr_lsb;
    } req_entry_t;

    localparam int REQ_DATA_W = $bits(req_entry_t);

endpackage

// File: rtl/free_tag_encoder.sv
// Lowest-zero encoder over the valid-bit vector of the request table.
// Ports:
//   vec      in   DEPTH   one bit per tag, 1 = tag in use
//   free_idx out  TAG_W   lowest index whose bit is 0 (0 when none)
//   any_free out  1       at least one bit of vec is 0
// Purely combinational.
module free_tag_encoder #(
    parameter int DEPTH = 32,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] vec,
    output logic [TAG_W-1:0] free_idx,
    output logic             any_free
);

    // Scan from the top down so the last assignment wins with the lowest index.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vec[i]) begin
                free_idx = TAG_W'(i);
            end
        end
    end

    assign any_free = ~(&vec);

endmodule

// File: rtl/slave_request_recorder.sv
// Tag-indexed table of outstanding non-posted AXI-slave requests.
// Records one entry per issued request, advertises the lowest free tag, lets
// the completion side look an entry up by tag and then retire it.
// Ports:
//   clk, arst                       clock, asynchronous active-low reset
//   req_wr_en/addr/data             record a request into a tag
//   alloc_tag, alloc_valid          lowest free tag / any tag free
//   cpl_rd_en/addr                  look up an entry by tag
//   cpl_rd_data, cpl_rd_hit         lookup result, one cycle after cpl_rd_en
//   cpl_free_en/tag                 retire an entry
//   occupancy, full, empty          table fill status
//   err_dup_wr, err_bad_free        one-cycle error pulses
//
// Handshake: every *_en input is a single-cycle command sampled on the rising
// clk edge; there is no backpressure. Writes are only legal while alloc_valid
// is 1. Illegal commands are dropped and flagged on the matching error pulse
// in the following cycle.
module slave_request_recorder #(
    parameter  int DEPTH      = slave_bridge_pkg::DEPTH,
    parameter  int REQ_DATA_W = slave_bridge_pkg::REQ_DATA_W,
    localparam int TAG_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  req_wr_en,
    input  logic [TAG_W-1:0]      req_wr_addr,
    input  logic [REQ_DATA_W-1:0] req_wr_data,
    output logic [TAG_W-1:0]      alloc_tag,
    output logic                  alloc_valid,
    input  logic                  cpl_rd_en,
    input  logic [TAG_W-1:0]      cpl_rd_addr,
    output logic [REQ_DATA_W-1:0] cpl_rd_data,
    output logic                  cpl_rd_hit,
    input  logic                  cpl_free_en,
    input  logic [TAG_W-1:0]      cpl_free_tag,
    output logic [TAG_W:0]        occupancy,
    output logic                  full,
    output logic                  empty,
    output logic                  err_dup_wr,
    output logic                  err_bad_free
);

    localparam int OCC_W = TAG_W + 1;

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [REQ_DATA_W-1:0] mem [DEPTH];
    logic [OCC_W-1:0]      occ_q;

    logic wr_ok;
    logic wr_dup;
    logic free_ok;
    logic free_bad;

    // Both commands are judged against the pre-edge valid bits. For the same
    // tag exactly one of them can be legal, so the entry ends up invalid when
    // it was valid (free wins) and valid when it was invalid (write wins).
    assign wr_ok    = req_wr_en   &&  !valid_q[req_wr_addr];
    assign wr_dup   = req_wr_en   &&   valid_q[req_wr_addr];
    assign free_ok  = cpl_free_en &&   valid_q[cpl_free_tag];
    assign free_bad = cpl_free_en &&  !valid_q[cpl_free_tag];

    always_comb begin
        valid_d = valid_q;
        if (free_ok) begin
            valid_d[cpl_free_tag] = 1'b0;
        end
        if (wr_ok) begin
            valid_d[req_wr_addr] = 1'b1;
        end
    end

    // Occupancy moves only on accepted operations, so it stays in 0..DEPTH.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            valid_q      <= '0;
            occ_q        <= '0;
            err_dup_wr   <= 1'b0;
            err_bad_free <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            occ_q        <= occ_q + OCC_W'(wr_ok) - OCC_W'(free_ok);
            err_dup_wr   <= wr_dup;
            err_bad_free <= free_bad;
        end
    end

    // Payload storage carries no reset; valid_q qualifies every entry.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[req_wr_addr] <= req_wr_data;
        end
    end

    // Lookup samples the pre-edge contents and valid bit, so a same-cycle
    // write or free on the looked-up tag is not visible in the result.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cpl_rd_data <= '0;
            cpl_rd_hit  <= 1'b0;
        end else if (cpl_rd_en) begin
            cpl_rd_data <= mem[cpl_rd_addr];
            cpl_rd_hit  <= valid_q[cpl_rd_addr];
        end
    end

    free_tag_encoder #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_free_tag_encoder (
        .vec      (valid_q),
        .free_idx (alloc_tag),
        .any_free (alloc_valid)
    );

    assign occupancy = occ_q;
    assign full      = (occ_q == OCC_W'(DEPTH));
    assign empty     = (occ_q == '0);

endmodule
